// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm controller and its neighbours.
// The bundle carries the tick and time inputs, the alarm time, and the arm/snooze/stop controls.
// It also carries the sound enable, the state and the snooze count back out.
// master: the timekeeping/button side (drives the inputs, observes the outputs).
// slave:  the alarm controller itself.
interface alarm_controller_if;
  logic       tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;
  logic       arm;
  logic       snooze_btn;
  logic       stop_btn;
  logic       sound_en;
  logic [1:0] state;
  logic [2:0] snooze_cnt;

  modport master (
    output tick_1hz, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
           arm, snooze_btn, stop_btn,
    input  sound_en, state, snooze_cnt
  );

  modport slave (
    input  tick_1hz, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
           arm, snooze_btn, stop_btn,
    output sound_en, state, snooze_cnt
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm sequencer: arms, rings on a time match, snoozes, auto-silences and drives the tone enable.
// Latency: 1 clk from a qualifying input cycle to the state/sound_en change.
// Backpressure: none; all inputs are strobes or levels and are consumed in the cycle they are seen.
// Ports:
//   clk    - system clock, all logic on posedge
//   reset  - synchronous active-high reset, overrides every other input
//   bus    - slave side of alarm_controller_if (time, alarm time, controls in;
//            sound_en, state, snooze_cnt out)
module alarm_controller #(
  parameter int RING_TIMEOUT_SEC = 60,  // 1..255
  parameter int SNOOZE_SEC       = 300, // 1..1023
  parameter int MAX_SNOOZE       = 3    // 0..7
) (
  input  logic               clk,
  input  logic               reset,
  alarm_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  localparam logic [7:0] RING_LAST  = 8'(RING_TIMEOUT_SEC - 1);
  localparam logic [9:0] SNZ_LAST   = 10'(SNOOZE_SEC - 1);
  localparam logic [2:0] SNZ_LIMIT  = 3'(MAX_SNOOZE);

  state_t     st_q;
  logic       sound_q;
  logic [2:0] snz_used_q;
  logic [7:0] ring_cnt;
  logic [9:0] snz_timer;
  logic       match;

  // The seconds==0 term confines the match to the first tick of the alarm
  // minute, so an event cannot retrigger within that minute.
  assign match = bus.tick_1hz
               & (bus.cur_hour == bus.alm_hour)
               & (bus.cur_min  == bus.alm_min)
               & (bus.cur_sec  == 6'd0);

  assign bus.state      = st_q;
  assign bus.sound_en   = sound_q;
  assign bus.snooze_cnt = snz_used_q;

  // sound_en is written alongside every transition so that it always equals
  // (next state == RINGING) without a separate decode stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= DISARMED;
      sound_q    <= 1'b0;
      snz_used_q <= 3'd0;
      ring_cnt   <= 8'd0;
      snz_timer  <= 10'd0;
    end else if (!bus.arm) begin
      // Disarm beats every other event in every state.
      st_q       <= DISARMED;
      sound_q    <= 1'b0;
      snz_used_q <= 3'd0;
      ring_cnt   <= 8'd0;
      snz_timer  <= 10'd0;
    end else begin
      case (st_q)
        DISARMED: begin
          st_q    <= ARMED;
          sound_q <= 1'b0;
        end

        ARMED: begin
          if (match) begin
            st_q       <= RINGING;
            sound_q    <= 1'b1;
            ring_cnt   <= 8'd0;
            snz_used_q <= 3'd0;
          end
        end

        RINGING: begin
          if (bus.stop_btn) begin
            st_q    <= ARMED;
            sound_q <= 1'b0;
          end else if (bus.snooze_btn && (snz_used_q < SNZ_LIMIT)) begin
            st_q       <= SNOOZE;
            sound_q    <= 1'b0;
            snz_timer  <= 10'd0;
            snz_used_q <= snz_used_q + 3'd1;
          end else if (bus.tick_1hz) begin
            // An exhausted snooze press falls through to here, so ringing
            // keeps counting toward auto-silence.
            if (ring_cnt == RING_LAST) begin
              st_q    <= ARMED;
              sound_q <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end
        end

        SNOOZE: begin
          if (bus.stop_btn) begin
            st_q    <= ARMED;
            sound_q <= 1'b0;
          end else if (bus.tick_1hz) begin
            if (snz_timer == SNZ_LAST) begin
              st_q     <= RINGING;
              sound_q  <= 1'b1;
              ring_cnt <= 8'd0;
            end else begin
              snz_timer <= snz_timer + 10'd1;
            end
          end
        end

        default: begin
          st_q    <= DISARMED;
          sound_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Sequences the alarm tone generator in the alarm-clock design.
- Compares the running time against the programmed alarm time on each 1 Hz tick.
- Manages the arm, ring, snooze and stop states, auto-silences after a timeout, and drives the tone generator's enable input.
- Sits between the timekeeping counters, the debounced button/switch inputs and the alarm sound generator.

Parameters:
- RING_TIMEOUT_SEC, 60: ticks of continuous ringing before auto-silence (range 1..255).
- SNOOZE_SEC, 300: ticks spent in snooze before re-ringing (range 1..1023).
- MAX_SNOOZE, 3: maximum snoozes per alarm event (range 0..7).

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- tick_1hz, input, 1: one-clk-wide strobe, once per second, aligned with the cur_* update.
- cur_hour, input, 5: current hour, binary 0..23.
- cur_min, input, 6: current minute, binary 0..59.
- cur_sec, input, 6: current second, binary 0..59.
- alm_hour, input, 5: alarm hour, binary 0..23.
- alm_min, input, 6: alarm minute, binary 0..59.
- arm, input, 1: level; 1 = alarm armed (slide switch).
- snooze_btn, input, 1: one-clk pulse (debounced, edge-detected upstream).
- stop_btn, input, 1: one-clk pulse (debounced, edge-detected upstream).
- sound_en, output, 1: enable to the tone generator; registered.
- state, output, 2: DISARMED=0, ARMED=1, RINGING=2, SNOOZE=3.
- snooze_cnt, output, 3: snoozes used in the current alarm event.

Behaviour:
- Reset (reset=1 at posedge):
  - state=DISARMED, sound_en=0, snooze_cnt=0.
  - Internal ring_cnt (8 b) and snz_timer (10 b) cleared.
  - Reset overrides every other input.
- match = tick_1hz & (cur_hour==alm_hour) & (cur_min==alm_min) & (cur_sec==0).
  - Fires at most once per alarm minute, so no retrigger latch is needed.
- Disarm: arm=0 in any state → DISARMED on the next edge.
  - sound_en=0, snooze_cnt=0, both timers cleared.
  - Disarm has priority over every other event.
- DISARMED: arm=1 → ARMED.
- ARMED: match → RINGING, with ring_cnt=0 and snooze_cnt=0.
  - snooze_btn and stop_btn are ignored in ARMED.
- RINGING, priority order (highest first):
  - stop_btn → ARMED.
  - snooze_btn with snooze_cnt<MAX_SNOOZE → SNOOZE, snz_timer=0, snooze_cnt+1.
  - tick_1hz with ring_cnt==RING_TIMEOUT_SEC-1 → ARMED (auto-silence).
  - tick_1hz otherwise → ring_cnt+1.
  - snooze_btn with snooze_cnt==MAX_SNOOZE is ignored; ringing continues and the tick rules still apply.
  - snooze_btn and stop_btn in the same cycle: stop wins.
  - stop_btn and timeout in the same cycle: ARMED (identical result).
- SNOOZE, priority order (highest first):
  - stop_btn → ARMED.
  - tick_1hz with snz_timer==SNOOZE_SEC-1 → RINGING, ring_cnt=0.
  - tick_1hz otherwise → snz_timer+1.
  - snooze_btn is ignored in SNOOZE.
- snooze_cnt holds its value through RINGING/SNOOZE cycles.
  - Cleared only on reset, on disarm, or on entry to RINGING from ARMED.
- Outputs:
  - sound_en is registered and equals (next state == RINGING).
  - sound_en and state change on the same edge.
  - Latency is 1 clk from a qualifying input cycle to the state/sound_en change.
- Width rules:
  - Counters are compared for equality only and never wrap.
  - Parameter ranges guarantee fit within the counter widths.
- Alarm time changes while RINGING or SNOOZE do not affect the current event.

Test Plan (bench parameters RING_TIMEOUT_SEC=4, SNOOZE_SEC=5, MAX_SNOOZE=2; ticks every 10 clk):
- Reset with arm=1 held → state=0, sound_en=0, snooze_cnt=0 during reset; state=1 one clk after reset deasserts.
- Arm, alm=07:30, time reaches 07:30:00 with tick → state=2 and sound_en=1 on the next edge; the tick at 07:29:59 causes no change.
- Ringing, no buttons → after 4 ticks state=1, sound_en=0, on the edge after the 4th tick.
- Snooze path:
  - Ringing, snooze_btn → state=3, snooze_cnt=1, sound_en=0.
  - After 5 ticks → state=2, sound_en=1.
  - Second snooze → snooze_cnt=2.
  - Third snooze_btn is ignored: state stays 2, snooze_cnt stays 2.
- Ringing, snooze_btn and stop_btn in the same clk → state=1, snooze_cnt unchanged.
- SNOOZE, arm dropped → state=0, snooze_cnt=0, sound_en=0 next edge; re-arm then match → ringing with snooze_cnt=0.
